// File: rtl/wb_sdram_tester.sv
`timescale 1ns/1ps
// Wishbone B4 pipelined memory tester: writes a pattern over a word range,
// reads it back in order and counts mismatches against a regenerated pattern.
module wb_sdram_tester #(
  parameter int DW      = 16,
  parameter int AW      = 24,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [AW-1:0]   num_words,
  input  logic [1:0]      pattern_sel,
  input  logic [15:0]     seed,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [15:0]     err_count,
  output logic [AW-1:0]   first_err_addr,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_stall_i
);

  localparam int             WDW       = $clog2(TIMEOUT) + 1;
  localparam logic [3:0]     MAX_OUT_C = 4'(MAX_OUT);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [DW-1:0]  WALK_INIT = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WDRAIN, S_GAP, S_READ, S_RDRAIN, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   base_r, nwords_r, issued;
  logic [1:0]      psel_r;
  logic [15:0]     seed_r, seed_eff;
  logic [3:0]      outst;
  logic [WDW-1:0]  wd;
  // Issue-side and check-side generators are independent so read checking
  // follows the ack order, not the request order.
  logic [AW-1:0]   iss_adr, chk_adr;
  logic [DW-1:0]   iss_walk, chk_walk;
  logic [15:0]     iss_lfsr, chk_lfsr;
  logic [15:0]     err_r;
  logic [AW-1:0]   first_r;
  logic            timeout_r, pass_r, done_r;
  logic            stb, accept, ack, in_run, in_read, wd_fire;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [DW-1:0] pat(input logic [1:0] sel, input logic [AW-1:0] a,
                                        input logic [DW-1:0] w, input logic [15:0] l);
    case (sel)
      2'd0:    return DW'(a);
      2'd1:    return ~DW'(a);
      2'd2:    return DW'(l);
      default: return w;
    endcase
  endfunction

  assign seed_eff = (seed == 16'h0000) ? 16'hACE1 : seed;

  // Next-state decode and bus request qualification.
  always_comb begin
    state_nx = state;
    in_run   = (state == S_WRITE) || (state == S_WDRAIN) || (state == S_READ) || (state == S_RDRAIN);
    in_read  = (state == S_READ) || (state == S_RDRAIN);
    stb      = ((state == S_WRITE) || (state == S_READ)) && (issued < nwords_r) && (outst < MAX_OUT_C);
    accept   = stb && !wb_stall_i;
    ack      = wb_ack_i && (outst != 4'd0);
    wd_fire  = in_run && (outst != 4'd0) && !ack && (wd == WD_LAST);
    case (state)
      S_IDLE:   if (start) state_nx = (num_words == '0) ? S_DONE : S_WRITE;
      S_WRITE:  if (wd_fire) state_nx = S_DONE; else if (issued == nwords_r) state_nx = S_WDRAIN;
      S_WDRAIN: if (wd_fire) state_nx = S_DONE; else if (outst == 4'd0) state_nx = S_GAP;
      S_GAP:    state_nx = S_READ;
      S_READ:   if (wd_fire) state_nx = S_DONE; else if (issued == nwords_r) state_nx = S_RDRAIN;
      S_RDRAIN: if (wd_fire || outst == 4'd0) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register, generators, counters and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      base_r    <= '0;
      nwords_r  <= '0;
      issued    <= '0;
      psel_r    <= '0;
      seed_r    <= '0;
      outst     <= '0;
      wd        <= '0;
      iss_adr   <= '0;
      chk_adr   <= '0;
      iss_walk  <= '0;
      chk_walk  <= '0;
      iss_lfsr  <= '0;
      chk_lfsr  <= '0;
      err_r     <= '0;
      first_r   <= '0;
      timeout_r <= 1'b0;
      pass_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= (state == S_DONE);
      if (state == S_IDLE && start) begin
        base_r    <= base_addr;
        nwords_r  <= num_words;
        psel_r    <= pattern_sel;
        seed_r    <= seed_eff;
        issued    <= '0;
        outst     <= '0;
        wd        <= '0;
        iss_adr   <= base_addr;
        iss_walk  <= WALK_INIT;
        iss_lfsr  <= seed_eff;
        err_r     <= '0;
        first_r   <= '0;
        timeout_r <= 1'b0;
        pass_r    <= 1'b0;
      end
      if (in_run) begin
        if (accept && !ack)      outst <= outst + 4'd1;
        else if (ack && !accept) outst <= outst - 4'd1;
        if (accept) begin
          issued   <= issued + AW'(1);
          iss_adr  <= iss_adr + AW'(1);
          iss_walk <= {iss_walk[DW-2:0], iss_walk[DW-1]};
          iss_lfsr <= lfsr_next(iss_lfsr);
        end
        if (ack || outst == 4'd0) wd <= '0;
        else                      wd <= wd + WDW'(1);
        if (wd_fire) timeout_r <= 1'b1;
        if (in_read && ack) begin
          if (wb_dat_i != pat(psel_r, chk_adr, chk_walk, chk_lfsr)) begin
            if (err_r == 16'h0000) first_r <= chk_adr;
            if (err_r != 16'hFFFF) err_r <= err_r + 16'd1;
          end
          chk_adr  <= chk_adr + AW'(1);
          chk_walk <= {chk_walk[DW-2:0], chk_walk[DW-1]};
          chk_lfsr <= lfsr_next(chk_lfsr);
        end
      end
      if (state == S_GAP) begin
        issued   <= '0;
        wd       <= '0;
        iss_adr  <= base_r;
        iss_walk <= WALK_INIT;
        iss_lfsr <= seed_r;
        chk_adr  <= base_r;
        chk_walk <= WALK_INIT;
        chk_lfsr <= seed_r;
      end
      if (state == S_DONE) pass_r <= (err_r == 16'h0000) && !timeout_r;
    end
  end

  assign busy           = (state != S_IDLE);
  assign done           = done_r;
  assign pass           = pass_r;
  assign timeout        = timeout_r;
  assign err_count      = err_r;
  assign first_err_addr = first_r;
  assign wb_cyc_o       = in_run;
  assign wb_stb_o       = stb;
  assign wb_we_o        = (state == S_WRITE) || (state == S_WDRAIN);
  assign wb_adr_o       = iss_adr;
  assign wb_dat_o       = pat(psel_r, iss_adr, iss_walk, iss_lfsr);
  assign wb_sel_o       = '1;

endmodule

// File: tb/tb_wb_sdram_tester.sv
`timescale 1ns/1ps
// Directed bench for wb_sdram_tester with a behavioural pipelined memory slave.
module tb_wb_sdram_tester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] base_addr = '0;
  logic [23:0] num_words = '0;
  logic [1:0]  pattern_sel = '0;
  logic [15:0] seed = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [23:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_stall_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave configuration, written only by the test tasks.
  int stall_mode = 0;
  int ack_limit  = 1 << 30;
  int corrupt_en = 0;

  // Slave and monitor state, written only by the slave process.
  typedef struct packed { logic we; logic [23:0] adr; } req_t;
  req_t        pend[$];
  logic [15:0] mem [logic [23:0]];
  logic [23:0] acc_adr[$];
  logic [15:0] acc_dat[$];
  logic        acc_we[$];
  logic [15:0] rd_dat[$];
  int          tb_out = 0, max_out = 0, stall_viol = 0, acks_given = 0, stall_ph = 0;
  bit          cyc_seen = 0;
  logic        prev_stalled = 1'b0, prev_we = 1'b0;
  logic [23:0] prev_adr = '0;
  logic [15:0] prev_dat = '0;
  req_t        r;
  logic [15:0] d;

  wb_sdram_tester #(.DW(16), .AW(24), .MAX_OUT(4), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .pattern_sel(pattern_sel), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
  );

  always #5 clk = ~clk;

  // Memory slave: in-order acks, at least one cycle of latency, optional stall,
  // ack suppression and read-data corruption; also records bus traffic.
  always @(posedge clk) begin
    stall_ph++;
    if (!rst_n) begin
      pend.delete();
      wb_ack_i     <= 1'b0;
      wb_dat_i     <= '0;
      wb_stall_i   <= 1'b0;
      tb_out       = 0;
      prev_stalled = 1'b0;
    end else begin
      if (start && !busy) begin
        acc_adr.delete(); acc_dat.delete(); acc_we.delete(); rd_dat.delete();
        max_out = 0; stall_viol = 0; cyc_seen = 0; acks_given = 0;
      end
      if (wb_cyc_o) cyc_seen = 1;
      if (prev_stalled && wb_stb_o &&
          (wb_adr_o !== prev_adr || wb_dat_o !== prev_dat || wb_we_o !== prev_we))
        stall_viol++;
      prev_stalled = wb_cyc_o && wb_stb_o && wb_stall_i;
      prev_adr = wb_adr_o; prev_dat = wb_dat_o; prev_we = wb_we_o;
      if (wb_ack_i && tb_out > 0) tb_out--;
      if (pend.size() > 0 && acks_given < ack_limit) begin
        r = pend.pop_front();
        acks_given++;
        d = 16'h0000;
        if (!r.we) begin
          d = mem.exists(r.adr) ? mem[r.adr] : 16'h0000;
          if (corrupt_en != 0 && (r.adr == 24'd5 || r.adr == 24'd9)) d = d ^ 16'h0001;
          rd_dat.push_back(d);
        end
        wb_ack_i <= 1'b1;
        wb_dat_i <= d;
      end else begin
        wb_ack_i <= 1'b0;
      end
      if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
        tb_out++;
        acc_adr.push_back(wb_adr_o);
        acc_dat.push_back(wb_dat_o);
        acc_we.push_back(wb_we_o);
        if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
        pend.push_back({wb_we_o, wb_adr_o});
      end
      if (tb_out > max_out) max_out = tb_out;
      wb_stall_i <= (stall_mode == 1) && ((stall_ph % 4) != 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall_mode = 0; ack_limit = 1 << 30; corrupt_en = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic kick(input logic [23:0] b, input logic [23:0] n, input logic [1:0] ps, input logic [15:0] sd);
    @(negedge clk);
    base_addr = b; num_words = n; pattern_sel = ps; seed = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int c, output bit ok);
    c = 0;
    while (!done && c < maxc) begin
      @(negedge clk);
      c++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({busy, done, pass, timeout, wb_cyc_o, wb_stb_o, wb_we_o} !== 7'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000000", {busy, done, pass, timeout, wb_cyc_o, wb_stb_o, wb_we_o});
    end
    n_cmp++;
    if ({err_count, first_err_addr, wb_adr_o, wb_dat_o} !== 80'h0) begin
      n_bad++; $display("FAIL reset_values: err %h first %h adr %h dat %h want all 0", err_count, first_err_addr, wb_adr_o, wb_dat_o);
    end
    n_cmp++;
    if (wb_sel_o !== 2'b11) begin n_bad++; $display("FAIL sel: got %b want 11", wb_sel_o); end
  endtask

  task automatic test_basic();
    int c; bit ok;
    do_reset();
    kick(24'd0, 24'd16, 2'd0, 16'd0);
    repeat (3) @(negedge clk);
    // a second start while busy must not disturb the run
    num_words = 24'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, c, ok);
    n_cmp++;
    if ({ok, pass, timeout, busy} !== 4'b1100) begin
      n_bad++; $display("FAIL basic_done: got done/pass/timeout/busy %b want 1100", {ok, pass, timeout, busy});
    end
    n_cmp++;
    if (err_count !== 16'd0) begin n_bad++; $display("FAIL basic_err: got %0d want 0", err_count); end
    n_cmp++;
    if (acc_adr.size() != 32) begin n_bad++; $display("FAIL basic_accepts: got %0d want 32", acc_adr.size()); end
    for (int i = 0; i < 16 && i < acc_dat.size(); i++) begin
      n_cmp++;
      if ({acc_we[i], acc_adr[i], acc_dat[i]} !== {1'b1, 24'(i), 16'(i)}) begin
        n_bad++; $display("FAIL basic_wr[%0d]: we %b adr %h dat %h want 1 %h %h", i, acc_we[i], acc_adr[i], acc_dat[i], 24'(i), 16'(i));
      end
    end
    n_cmp++;
    if (rd_dat.size() != 16) begin n_bad++; $display("FAIL basic_reads: got %0d want 16", rd_dat.size()); end
    for (int i = 0; i < rd_dat.size(); i++) begin
      n_cmp++;
      if (rd_dat[i] !== 16'(i)) begin n_bad++; $display("FAIL basic_rd[%0d]: got %h want %h", i, rd_dat[i], 16'(i)); end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b want 0", done); end
  endtask

  task automatic test_wrap();
    int c; bit ok;
    logic [23:0] ea[4];
    logic [15:0] ed[4];
    ea = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    ed = '{16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE};
    do_reset();
    kick(24'hFFFFFE, 24'd4, 2'd1, 16'd0);
    wait_done(500, c, ok);
    n_cmp++;
    if ({ok, pass, err_count} !== {2'b11, 16'd0}) begin
      n_bad++; $display("FAIL wrap_result: done %b pass %b err %0d want 1 1 0", ok, pass, err_count);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({acc_adr[i], acc_dat[i]} !== {ea[i], ed[i]}) begin
        n_bad++; $display("FAIL wrap_wr[%0d]: adr %h dat %h want %h %h", i, acc_adr[i], acc_dat[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_lfsr_stall();
    int c; bit ok;
    logic [15:0] ed[5];
    int          ei[5];
    ed = '{16'h0001, 16'h8000, 16'h4000, 16'h2000, 16'h8010};
    ei = '{0, 1, 2, 3, 12};
    do_reset();
    stall_mode = 1;
    kick(24'd0, 24'd256, 2'd2, 16'd1);
    wait_done(8000, c, ok);
    n_cmp++;
    if ({ok, pass, err_count} !== {2'b11, 16'd0}) begin
      n_bad++; $display("FAIL lfsr_result: done %b pass %b err %0d want 1 1 0", ok, pass, err_count);
    end
    n_cmp++;
    if (max_out > 4 || max_out < 1) begin n_bad++; $display("FAIL lfsr_outstanding: max %0d want 1..4", max_out); end
    n_cmp++;
    if (stall_viol != 0) begin n_bad++; $display("FAIL lfsr_stall_hold: got %0d changes want 0", stall_viol); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (acc_dat[ei[i]] !== ed[i]) begin
        n_bad++; $display("FAIL lfsr_wr[%0d]: got %h want %h", ei[i], acc_dat[ei[i]], ed[i]);
      end
    end
  endtask

  task automatic test_patterns();
    int c; bit ok;
    do_reset();
    kick(24'd0, 24'd18, 2'd3, 16'd0);
    wait_done(1000, c, ok);
    n_cmp++;
    if ({ok, pass, acc_dat[0], acc_dat[15], acc_dat[16], acc_dat[17]} !==
        {2'b11, 16'h0001, 16'h8000, 16'h0001, 16'h0002}) begin
      n_bad++; $display("FAIL walk: done %b pass %b d0 %h d15 %h d16 %h d17 %h want 1 1 0001 8000 0001 0002",
                        ok, pass, acc_dat[0], acc_dat[15], acc_dat[16], acc_dat[17]);
    end
    kick(24'd100, 24'd2, 2'd2, 16'd0);
    wait_done(500, c, ok);
    n_cmp++;
    if ({ok, pass, acc_dat[0], acc_dat[1]} !== {2'b11, 16'hACE1, 16'h5670}) begin
      n_bad++; $display("FAIL seed_zero: done %b pass %b d0 %h d1 %h want 1 1 ace1 5670", ok, pass, acc_dat[0], acc_dat[1]);
    end
  endtask

  task automatic test_errors();
    int c; bit ok;
    do_reset();
    corrupt_en = 1;
    kick(24'd0, 24'd16, 2'd0, 16'd0);
    wait_done(2000, c, ok);
    n_cmp++;
    if ({ok, pass, timeout} !== 3'b100) begin
      n_bad++; $display("FAIL err_flags: done/pass/timeout %b want 100", {ok, pass, timeout});
    end
    n_cmp++;
    if (err_count !== 16'd2) begin n_bad++; $display("FAIL err_count: got %0d want 2", err_count); end
    n_cmp++;
    if (first_err_addr !== 24'd5) begin n_bad++; $display("FAIL first_err_addr: got %h want 000005", first_err_addr); end
  endtask

  task automatic test_timeout();
    int c; bit ok;
    do_reset();
    ack_limit = 3;
    kick(24'd0, 24'd16, 2'd0, 16'd0);
    wait_done(3000, c, ok);
    n_cmp++;
    if ({ok, timeout, pass, wb_cyc_o, wb_stb_o, busy} !== 6'b110000) begin
      n_bad++; $display("FAIL timeout_flags: done/timeout/pass/cyc/stb/busy %b want 110000", {ok, timeout, pass, wb_cyc_o, wb_stb_o, busy});
    end
    n_cmp++;
    if (c < 1024 || c > 1100) begin n_bad++; $display("FAIL timeout_latency: got %0d cycles want 1024..1100", c); end
  endtask

  task automatic test_zero_words();
    int c; bit ok;
    do_reset();
    kick(24'd0, 24'd0, 2'd0, 16'd0);
    wait_done(20, c, ok);
    // done is visible one sampling point after kick returns: two edges after start
    n_cmp++;
    if ({ok, c} !== {1'b1, 32'd1}) begin n_bad++; $display("FAIL zero_latency: done %b after %0d want 1 after 1", ok, c); end
    n_cmp++;
    if ({pass, err_count, cyc_seen} !== {1'b1, 16'd0, 1'b0}) begin
      n_bad++; $display("FAIL zero_result: pass %b err %0d cyc_seen %b want 1 0 0", pass, err_count, cyc_seen);
    end
  endtask

  task automatic test_reset_mid_read();
    int c; bit ok;
    do_reset();
    kick(24'd0, 24'd16, 2'd0, 16'd0);
    c = 0;
    while (!(wb_cyc_o && !wb_we_o) && c < 500) begin @(negedge clk); c++; end
    n_cmp++;
    if (c >= 500) begin n_bad++; $display("FAIL reach_read: got no read phase want one within 500 cycles"); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, busy} !== 3'b000) begin
      n_bad++; $display("FAIL mid_reset: cyc/stb/busy %b want 000", {wb_cyc_o, wb_stb_o, busy});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    kick(24'd40, 24'd8, 2'd1, 16'd0);
    wait_done(1000, c, ok);
    n_cmp++;
    if ({ok, pass, err_count} !== {2'b11, 16'd0}) begin
      n_bad++; $display("FAIL after_reset_run: done %b pass %b err %0d want 1 1 0", ok, pass, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_lfsr_stall();
    test_patterns();
    test_errors();
    test_timeout();
    test_zero_words();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
